// File: rtl/mem_latency_slave.sv
// Data-memory slave for the core's DAD/DDT bus: fixed-latency ack, sub-word lanes, stdout/exit MMIO ports,
// error strobe on misaligned or unmapped access, and a high-water address tracker.
module mem_latency_slave #(
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0800_0000,
  parameter int                LATENCY     = 1,
  parameter logic [ADDR_W-1:0] STDOUT_ADDR = 32'hf000_0000,
  parameter logic [ADDR_W-1:0] EXIT_ADDR   = 32'hff00_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MREQ,
  input  logic              WRITE,
  input  logic [1:0]        SIZE,
  input  logic [ADDR_W-1:0] DAD,
  input  logic [31:0]       DDT_I,
  output logic [31:0]       DDT_O,
  output logic              DDT_OE,
  output logic              ACKD_n,
  output logic              stdout_valid,
  output logic [7:0]        stdout_char,
  output logic              exit_req,
  output logic              err,
  output logic [ADDR_W-1:0] max_addr
);

  localparam int                IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] SPAN     = ADDR_W'(DEPTH_WORDS) << 2;
  localparam logic [3:0]        CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [ADDR_W-1:0] a_q;
  logic [1:0]        size_q;
  logic              wr_q;
  logic [31:0]       wd_q;
  logic [ADDR_W-1:0] max_q;
  logic              exit_q;
  logic [31:0]       ram [DEPTH_WORDS];

  logic [ADDR_W-1:0] off;
  logic [IDX_W-1:0]  idx;
  logic              misalign, is_stdout, is_exit, mmio, in_range, ram_ok, is_ack;
  logic [31:0]       word, rd_lane, wr_word;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (MREQ) begin
        cnt_nxt   = CNT_INIT;
        state_nxt = (LATENCY <= 1) ? ACK : WAIT;
      end
      // The ack cycle starts on the edge where the counter reaches zero.
      WAIT: if (!MREQ) begin
        state_nxt = IDLE;
      end else begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = ACK;
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      a_q    <= '0;
      size_q <= 2'b00;
      wr_q   <= 1'b0;
      wd_q   <= 32'h0;
      max_q  <= '0;
      exit_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && MREQ) begin
        a_q    <= DAD;
        size_q <= SIZE;
        wr_q   <= WRITE;
        wd_q   <= DDT_I;
      end
      if (is_ack) begin
        if (wr_q && is_exit && !misalign) exit_q <= 1'b1;
        if (ram_ok && a_q > max_q)        max_q  <= a_q;
      end
    end
  end

  assign off       = a_q - BASE_ADDR;
  assign idx       = off[IDX_W+1:2];
  assign misalign  = (size_q == 2'b00 && a_q[1:0] != 2'b00) || (size_q == 2'b01 && a_q[0]);
  assign is_stdout = (a_q == STDOUT_ADDR);
  assign is_exit   = (a_q == EXIT_ADDR);
  assign mmio      = is_stdout || is_exit;
  assign in_range  = (a_q >= BASE_ADDR) && (off < SPAN) && !mmio;
  assign ram_ok    = in_range && !misalign;
  assign is_ack    = (state == ACK);
  assign word      = ram[idx];

  always_comb begin
    rd_lane = 32'h0;
    wr_word = word;
    case (size_q)
      2'b00: begin
        rd_lane = word;
        wr_word = wd_q;
      end
      2'b01: begin
        if (a_q[1]) begin
          rd_lane = {16'h0, word[31:16]};
          wr_word = {wd_q[15:0], word[15:0]};
        end else begin
          rd_lane = {16'h0, word[15:0]};
          wr_word = {word[31:16], wd_q[15:0]};
        end
      end
      default: begin
        case (a_q[1:0])
          2'd0: begin rd_lane = {24'h0, word[7:0]};   wr_word = {word[31:8], wd_q[7:0]}; end
          2'd1: begin rd_lane = {24'h0, word[15:8]};  wr_word = {word[31:16], wd_q[7:0], word[7:0]}; end
          2'd2: begin rd_lane = {24'h0, word[23:16]}; wr_word = {word[31:24], wd_q[7:0], word[15:0]}; end
          default: begin rd_lane = {24'h0, word[31:24]}; wr_word = {wd_q[7:0], word[23:0]}; end
        endcase
      end
    endcase
  end

  // RAM is deliberately left out of reset; the store commits on the edge leaving ACK.
  always_ff @(posedge clk) begin
    if (is_ack && wr_q && ram_ok) ram[idx] <= wr_word;
  end

  assign ACKD_n       = !is_ack;
  assign DDT_OE       = is_ack && !wr_q;
  assign DDT_O        = (is_ack && !wr_q && ram_ok) ? rd_lane : 32'h0;
  assign stdout_valid = is_ack && wr_q && is_stdout && !misalign;
  assign stdout_char  = stdout_valid ? wd_q[7:0] : 8'h0;
  assign exit_req     = exit_q || (is_ack && wr_q && is_exit && !misalign);
  assign err          = is_ack && (misalign || (!in_range && !mmio));
  assign max_addr     = max_q;

endmodule

// File: tb/tb_mem_latency_slave.sv
// Scoreboard bench for mem_latency_slave at LATENCY=3: expectations queued per request, checked at each ack.
module tb_mem_latency_slave;

  localparam int          LAT    = 3;
  localparam logic [31:0] STDOUT = 32'hf000_0000;
  localparam logic [31:0] EXITA  = 32'hff00_0000;

  logic        clk, rst, MREQ, WRITE;
  logic [1:0]  SIZE;
  logic [31:0] DAD, DDT_I, DDT_O, max_addr;
  logic        DDT_OE, ACKD_n, stdout_valid, exit_req, err;
  logic [7:0]  stdout_char;

  mem_latency_slave #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .MREQ(MREQ), .WRITE(WRITE), .SIZE(SIZE), .DAD(DAD),
    .DDT_I(DDT_I), .DDT_O(DDT_O), .DDT_OE(DDT_OE), .ACKD_n(ACKD_n),
    .stdout_valid(stdout_valid), .stdout_char(stdout_char), .exit_req(exit_req),
    .err(err), .max_addr(max_addr)
  );

  typedef struct {
    logic        wr;
    logic [31:0] data;
    logic        err;
    logic        stdv;
    logic [7:0]  ch;
    int          start;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   ack_cnt = 0;
  int   stdout_cnt = 0;
  logic held_prev = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Latency is counted from the edge that samples MREQ to the edge where ACKD_n is first seen low.
  always @(negedge clk) begin
    if (!ACKD_n) begin
      exp_t e;
      ack_cnt++;
      if (sb.size() == 0) begin
        chk("spurious_ack", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("latency", 32'(cyc + 1 - e.start), 32'(LAT));
        chk("err", {31'h0, err}, {31'h0, e.err});
        chk("ddt_oe", {31'h0, DDT_OE}, {31'h0, !e.wr});
        chk("ddt_o", DDT_O, e.data);
        chk("stdout_valid", {31'h0, stdout_valid}, {31'h0, e.stdv});
        chk("stdout_char", {24'h0, stdout_char}, {24'h0, e.ch});
      end
    end else if (stdout_valid || err || DDT_OE) begin
      chk("strobe_outside_ack", 32'd1, 32'd0);
    end
    if (stdout_valid) stdout_cnt++;
  end

  task automatic access(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_d, input logic exp_e, input logic hold);
    exp_t e;
    logic got;
    e.wr    = w;
    e.data  = w ? 32'h0 : exp_d;
    e.err   = exp_e;
    e.stdv  = w && (a == STDOUT) && !exp_e;
    e.ch    = e.stdv ? d[7:0] : 8'h0;
    // A request held through the ack cycle is only sampled on the edge after it.
    e.start = held_prev ? cyc + 2 : cyc + 1;
    sb.push_back(e);
    MREQ = 1'b1; WRITE = w; SIZE = sz; DAD = a; DDT_I = d;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!ACKD_n) begin got = 1'b1; break; end
    end
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
    if (!hold) begin
      MREQ = 1'b0;
      @(negedge clk);
    end
    held_prev = hold;
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_ackd_n"}, {31'h0, ACKD_n}, 32'd1);
    chk({tag, "_ddt_o"}, DDT_O, 32'h0);
    chk({tag, "_ddt_oe"}, {31'h0, DDT_OE}, 32'd0);
    chk({tag, "_stdout_valid"}, {31'h0, stdout_valid}, 32'd0);
    chk({tag, "_stdout_char"}, {24'h0, stdout_char}, 32'd0);
    chk({tag, "_exit_req"}, {31'h0, exit_req}, 32'd0);
    chk({tag, "_err"}, {31'h0, err}, 32'd0);
    chk({tag, "_max_addr"}, max_addr, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved;
    rst = 1'b0; MREQ = 1'b0; WRITE = 1'b0; SIZE = 2'b00; DAD = 32'h0; DDT_I = 32'h0;
    repeat (3) @(negedge clk);
    reset_vals("reset");
    rst = 1'b1;
    @(negedge clk);

    // word store/load and high-water mark
    access(1, 2'b00, 32'h0800_0010, 32'hDEADBEEF, 32'h0, 0, 0);
    access(0, 2'b00, 32'h0800_0010, 32'h0, 32'hDEADBEEF, 0, 0);
    chk("max_after_word", max_addr, 32'h0800_0010);

    // sub-word lanes
    access(1, 2'b10, 32'h0800_0011, 32'h0000_0055, 32'h0, 0, 0);
    access(0, 2'b00, 32'h0800_0010, 32'h0, 32'hDEAD55EF, 0, 0);
    access(0, 2'b01, 32'h0800_0012, 32'h0, 32'h0000DEAD, 0, 0);
    access(0, 2'b11, 32'h0800_0013, 32'h0, 32'h000000DE, 0, 0);
    access(0, 2'b01, 32'h0800_0010, 32'h0, 32'h000055EF, 0, 0);
    chk("max_after_sub", max_addr, 32'h0800_0013);
    access(1, 2'b00, 32'h0800_0014, 32'h01020304, 32'h0, 0, 0);
    access(1, 2'b01, 32'h0800_0016, 32'h0000BEEF, 32'h0, 0, 0);
    access(1, 2'b10, 32'h0800_0014, 32'h00000099, 32'h0, 0, 0);
    access(0, 2'b00, 32'h0800_0014, 32'h0, 32'hBEEF0399, 0, 0);

    // back-to-back loads with MREQ held across acks
    saved = ack_cnt;
    access(0, 2'b00, 32'h0800_0010, 32'h0, 32'hDEAD55EF, 0, 1);
    access(0, 2'b00, 32'h0800_0014, 32'h0, 32'hBEEF0399, 0, 1);
    access(0, 2'b00, 32'h0800_0010, 32'h0, 32'hDEAD55EF, 0, 0);
    chk("b2b_ack_count", 32'(ack_cnt - saved), 32'd3);

    // MMIO ports
    access(1, 2'b10, STDOUT, 32'h0000_0041, 32'h0, 0, 0);
    access(0, 2'b00, STDOUT, 32'h0, 32'h0, 0, 0);
    access(1, 2'b00, EXITA, 32'h0000_0001, 32'h0, 0, 0);
    chk("exit_req_set", {31'h0, exit_req}, 32'd1);
    repeat (5) @(negedge clk);
    chk("exit_req_sticky", {31'h0, exit_req}, 32'd1);
    chk("stdout_pulses", 32'(stdout_cnt), 32'd1);
    chk("max_after_mmio", max_addr, 32'h0800_0016);

    // errors and range boundaries
    access(1, 2'b00, 32'h0800_0000, 32'h0BADF00D, 32'h0, 0, 0);
    access(0, 2'b01, 32'h0800_0001, 32'h0, 32'h0, 1, 0);
    access(0, 2'b00, 32'h0000_0100, 32'h0, 32'h0, 1, 0);
    access(1, 2'b00, 32'h0800_0002, 32'hFFFFFFFF, 32'h0, 1, 0);
    access(1, 2'b00, 32'h07FF_FFFC, 32'hFFFFFFFF, 32'h0, 1, 0);
    access(0, 2'b00, 32'h0800_1000, 32'h0, 32'h0, 1, 0);
    access(0, 2'b00, 32'h0800_0000, 32'h0, 32'h0BADF00D, 0, 0);
    access(1, 2'b00, 32'h0800_0FFC, 32'h600D600D, 32'h0, 0, 0);
    access(0, 2'b00, 32'h0800_0FFC, 32'h0, 32'h600D600D, 0, 0);
    chk("max_at_top", max_addr, 32'h0800_0FFC);

    // MREQ dropped while waiting
    access(1, 2'b00, 32'h0800_0020, 32'hCAFEF00D, 32'h0, 0, 0);
    saved = ack_cnt;
    MREQ = 1'b1; WRITE = 1'b1; SIZE = 2'b00; DAD = 32'h0800_0020; DDT_I = 32'h11111111;
    @(negedge clk);
    MREQ = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_no_ack", 32'(ack_cnt - saved), 32'd0);
    access(0, 2'b00, 32'h0800_0020, 32'h0, 32'hCAFEF00D, 0, 0);

    // reset while a store is pending
    saved = ack_cnt;
    MREQ = 1'b1; WRITE = 1'b1; SIZE = 2'b00; DAD = 32'h0800_0020; DDT_I = 32'h22222222;
    @(negedge clk);
    rst = 1'b0;
    MREQ = 1'b0;
    #1;
    reset_vals("midreset");
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_no_ack", 32'(ack_cnt - saved), 32'd0);
    reset_vals("postreset");
    access(0, 2'b00, 32'h0800_0020, 32'h0, 32'hCAFEF00D, 0, 0);
    chk("max_after_reset", max_addr, 32'h0800_0020);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
